// File: rtl/debug_responder.sv
// debug_responder: UART command responder for pipeline debug.
// Dumps pipeline latches and registers, loads instruction memory, and controls run/step.
module debug_responder #(
  parameter int IF_ID_SIZE      = 64,
  parameter int ID_EX_SIZE      = 129,
  parameter int EX_MEM_SIZE     = 78,
  parameter int MEM_WB_SIZE     = 72,
  parameter int MAX_INSTRUCTION = 64
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [7:0]                         i_rx_data,
  input  logic                               i_rx_valid,
  output logic [7:0]                         o_tx_data,
  output logic                               o_tx_start,
  input  logic                               i_tx_done,
  input  logic [IF_ID_SIZE-1:0]              i_if_id,
  input  logic [ID_EX_SIZE-1:0]              i_id_ex,
  input  logic [EX_MEM_SIZE-1:0]             i_ex_mem,
  input  logic [MEM_WB_SIZE-1:0]             i_mem_wb,
  output logic [4:0]                         o_reg_addr,
  input  logic [31:0]                        i_reg_data,
  output logic                               o_imem_we,
  output logic [$clog2(MAX_INSTRUCTION)-1:0] o_imem_addr,
  output logic [31:0]                        o_imem_data,
  output logic                               o_step_mode,
  output logic                               o_run,
  output logic                               o_step,
  output logic                               o_overrun
);
  localparam int AW  = $clog2(MAX_INSTRUCTION);
  localparam int M1  = IF_ID_SIZE > ID_EX_SIZE ? IF_ID_SIZE : ID_EX_SIZE;
  localparam int M2  = EX_MEM_SIZE > MEM_WB_SIZE ? EX_MEM_SIZE : MEM_WB_SIZE;
  // extra headroom keeps every zero-extension strictly wider than its source, including a 32-bit register
  localparam int SRW = (M1 > M2 ? M1 : M2) + 40;
  localparam logic [7:0] N_IF  = 8'((IF_ID_SIZE + 7) / 8);
  localparam logic [7:0] N_IDX = 8'((ID_EX_SIZE + 7) / 8);
  localparam logic [7:0] N_EXM = 8'((EX_MEM_SIZE + 7) / 8);
  localparam logic [7:0] N_MWB = 8'((MEM_WB_SIZE + 7) / 8);
  localparam logic [8:0] MAXN  = 9'(MAX_INSTRUCTION);
  localparam logic [7:0] ACK_R = 8'h52;
  localparam logic [7:0] ACK_E = 8'h45;
  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] GET_COUNT   = 3'd1;
  localparam logic [2:0] LOAD        = 3'd2;
  localparam logic [2:0] TX_BYTE     = 3'd3;
  localparam logic [2:0] TX_WAIT     = 3'd4;
  localparam logic [2:0] TX_ACK      = 3'd5;
  localparam logic [2:0] TX_ACK_WAIT = 3'd6;

  logic [2:0]     r_state;
  logic [SRW-1:0] r_sr;
  logic [7:0]     r_cnt;
  logic           r_regs;
  logic [1:0]     r_bidx;
  logic [7:0]     r_ack;
  logic [7:0]     r_hold;
  logic           r_hold_v;
  logic [7:0]     r_nwords;
  logic [7:0]     r_widx;
  logic [23:0]    r_word;
  logic           r_armed;
  logic           w_cons;
  logic           w_rx_v;
  logic [7:0]     w_rx_d;
  logic [SRW-1:0] w_src;

  always_comb begin
    w_cons = (r_state == IDLE) || (r_state == GET_COUNT) || (r_state == LOAD);
    w_rx_v = w_cons && (r_hold_v || i_rx_valid);
    w_rx_d = r_hold_v ? r_hold : i_rx_data;
    w_src  = (r_regs && r_bidx == 2'd0) ? SRW'(i_reg_data) : r_sr;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_sr        <= '0;
      r_cnt       <= '0;
      r_regs      <= 1'b0;
      r_bidx      <= '0;
      r_ack       <= '0;
      r_hold      <= '0;
      r_hold_v    <= 1'b0;
      r_nwords    <= '0;
      r_widx      <= '0;
      r_word      <= '0;
      r_armed     <= 1'b0;
      o_tx_data   <= '0;
      o_tx_start  <= 1'b0;
      o_reg_addr  <= '0;
      o_imem_we   <= 1'b0;
      o_imem_addr <= '0;
      o_imem_data <= '0;
      o_step_mode <= 1'b0;
      o_run       <= 1'b0;
      o_step      <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_imem_we <= 1'b0;
      o_step    <= 1'b0;
      // a byte not consumed directly this cycle lands in the holding register
      if (i_rx_valid && !(w_cons && !r_hold_v)) begin
        r_hold   <= i_rx_data;
        r_hold_v <= 1'b1;
        if (r_hold_v && !w_cons) o_overrun <= 1'b1;
      end else if (w_cons) begin
        r_hold_v <= 1'b0;
      end
      case (r_state)
        IDLE: if (w_rx_v) begin
          r_ack  <= ACK_R;
          r_regs <= 1'b0;
          case (w_rx_d)
            8'h01: begin
              r_regs     <= 1'b1;
              r_bidx     <= '0;
              o_reg_addr <= '0;
              r_cnt      <= 8'd128;
              r_state    <= TX_BYTE;
            end
            8'h02: begin r_sr <= SRW'(i_if_id);  r_cnt <= N_IF;  r_state <= TX_BYTE; end
            8'h03: begin r_sr <= SRW'(i_id_ex);  r_cnt <= N_IDX; r_state <= TX_BYTE; end
            8'h04: begin r_sr <= SRW'(i_ex_mem); r_cnt <= N_EXM; r_state <= TX_BYTE; end
            8'h05: begin r_sr <= SRW'(i_mem_wb); r_cnt <= N_MWB; r_state <= TX_BYTE; end
            8'h07: r_state <= GET_COUNT;
            8'h08: begin o_step_mode <= 1'b0; o_run <= 1'b0; r_armed <= 1'b0; end
            8'h0A: o_step <= o_step_mode && r_armed;
            8'h0D: begin
              r_armed <= r_armed || o_step_mode;
              o_run   <= o_run || !o_step_mode;
            end
            8'h11: begin
              o_step_mode <= 1'b1;
              o_run       <= 1'b0;
              r_armed     <= 1'b0;
              r_state     <= TX_ACK;
            end
            default: begin r_ack <= ACK_E; r_state <= TX_ACK; end
          endcase
        end
        GET_COUNT: if (w_rx_v) begin
          if (w_rx_d == 8'd0 || {1'b0, w_rx_d} > MAXN) begin
            r_ack   <= ACK_E;
            r_state <= TX_ACK;
          end else begin
            r_nwords <= w_rx_d;
            r_widx   <= '0;
            r_bidx   <= '0;
            r_state  <= LOAD;
          end
        end
        LOAD: if (w_rx_v) begin
          r_bidx <= r_bidx + 2'd1;
          if (r_bidx != 2'd3) begin
            r_word <= {w_rx_d, r_word[23:8]};
          end else begin
            o_imem_data <= {w_rx_d, r_word};
            o_imem_addr <= r_widx[AW-1:0];
            o_imem_we   <= 1'b1;
            r_widx      <= r_widx + 8'd1;
            if (r_widx == r_nwords - 8'd1) begin
              r_ack   <= ACK_R;
              r_state <= TX_ACK;
            end
          end
        end
        TX_BYTE: begin
          o_tx_data  <= w_src[7:0];
          r_sr       <= w_src >> 8;
          o_tx_start <= 1'b1;
          r_state    <= TX_WAIT;
        end
        TX_WAIT: if (i_tx_done) begin
          o_tx_start <= 1'b0;
          r_cnt      <= r_cnt - 8'd1;
          r_bidx     <= r_bidx + 2'd1;
          if (r_regs && r_bidx == 2'd3) o_reg_addr <= o_reg_addr + 5'd1;
          r_state    <= (r_cnt == 8'd1) ? TX_ACK : TX_BYTE;
        end
        TX_ACK: begin
          o_tx_data  <= r_ack;
          o_tx_start <= 1'b1;
          r_state    <= TX_ACK_WAIT;
        end
        TX_ACK_WAIT: if (i_tx_done) begin
          o_tx_start <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_responder.sv
// tb_debug_responder: self-checking bench with a UART sink, byte/write scoreboards and a dump vector table.
module tb_debug_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         tx_done = 1'b0;
  logic [63:0]  if_id = '0;
  logic [128:0] id_ex = '0;
  logic [77:0]  ex_mem = '0;
  logic [71:0]  mem_wb = '0;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic [4:0]   reg_addr;
  logic [31:0]  reg_data;
  logic         imem_we;
  logic [5:0]   imem_addr;
  logic [31:0]  imem_data;
  logic         step_mode, run, step, overrun;

  debug_responder dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .i_if_id(if_id), .i_id_ex(id_ex), .i_ex_mem(ex_mem), .i_mem_wb(mem_wb),
    .o_reg_addr(reg_addr), .i_reg_data(reg_data),
    .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_data(imem_data),
    .o_step_mode(step_mode), .o_run(run), .o_step(step), .o_overrun(overrun)
  );

  function automatic logic [31:0] regval(logic [4:0] r);
    return {3'b101, r, 8'h5A, 3'b000, r, 8'hF0 ^ {3'b000, r}};
  endfunction
  assign reg_data = regval(reg_addr);

  typedef struct { logic [5:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [7:0] op; int sz; logic [135:0] val; } dv_t;

  int n_chk = 0, n_pass = 0, hs_err = 0, n_got = 0, n_step = 0;
  logic [7:0] exp_q[$];
  wr_t wq[$];
  wr_t mon_w;
  logic [7:0] sk_b;
  int sk_lat;
  bit sk_live;

  task automatic chk(string name, logic [135:0] act, logic [135:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // UART sink: random latency, checks stable data while start is high and a low gap after done
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        sk_b = tx_data; sk_live = 1'b1; sk_lat = $urandom_range(0, 3);
        repeat (sk_lat) begin
          @(negedge clk);
          if (!sk_live || !tx_start) sk_live = 1'b0;
          else if (tx_data !== sk_b) hs_err++;
        end
        if (sk_live) begin
          tx_done = 1'b1;
          @(negedge clk);
          tx_done = 1'b0;
          if (tx_start) hs_err++;
          n_got++;
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL tx_byte: got %02h expected none", sk_b);
          end else chk("tx_byte", sk_b, exp_q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (step) n_step++;
    if (imem_we) begin
      if (wq.size() == 0) begin
        n_chk++;
        $display("FAIL imem_write: got addr %0d data %08h expected none", imem_addr, imem_data);
      end else begin
        mon_w = wq.pop_front();
        chk("imem_addr", imem_addr, mon_w.a);
        chk("imem_data", imem_data, mon_w.d);
      end
    end
  end

  task automatic send(logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic drain(string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || tx_start || tx_done) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_done"}, k < 3000, 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic set_latch(logic [7:0] op, logic [135:0] v);
    case (op)
      8'h02:   if_id = v[63:0];
      8'h03:   id_ex = v[128:0];
      8'h04:   ex_mem = v[77:0];
      default: mem_wb = v[71:0];
    endcase
  endtask

  task automatic push_dump(logic [7:0] op, int sz, logic [135:0] m);
    for (int i = 0; i < (sz + 7) / 8; i++) exp_q.push_back(m[8*i +: 8]);
    exp_q.push_back(8'h52);
    set_latch(op, m);
  endtask

  dv_t tbl[5];
  logic [135:0] m;
  logic [31:0] rv;
  int k, g0, g1;

  initial begin
    tbl[0] = '{8'h02, 64,  136'h1122334455667788};
    tbl[1] = '{8'h03, 129, 136'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()})};
    tbl[2] = '{8'h04, 78,  136'({$urandom(), $urandom(), $urandom()})};
    tbl[3] = '{8'h05, 72,  136'({$urandom(), $urandom(), $urandom()})};
    tbl[4] = '{8'h02, 64,  {136{1'b1}}};

    repeat (2) @(negedge clk);
    chk("rst_outputs", {tx_start, tx_data, imem_we, imem_addr, imem_data, reg_addr, run, step, overrun, step_mode}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      m = tbl[t].val & ((136'd1 << tbl[t].sz) - 136'd1);
      push_dump(tbl[t].op, tbl[t].sz, m);
      @(negedge clk);
      rx_data = tbl[t].op; rx_valid = 1'b1;
      k = 0;
      do begin @(negedge clk); rx_valid = 1'b0; k++; end while (!tx_start && k < 6);
      chk("dump_latency", k <= 2, 1);
      set_latch(tbl[t].op, ~m);
      drain("dump");
    end

    for (int r = 0; r < 32; r++) begin
      rv = regval(5'(r));
      for (int b = 0; b < 4; b++) exp_q.push_back(rv[8*b +: 8]);
    end
    exp_q.push_back(8'h52);
    send(8'h01);
    drain("regs");

    wq.push_back('{6'd0, 32'h3C010001});
    wq.push_back('{6'd1, 32'h3C030003});
    exp_q.push_back(8'h52);
    send(8'h07); send(8'h02);
    send(8'h01); send(8'h00); send(8'h01); send(8'h3C);
    send(8'h03); send(8'h00); send(8'h03); send(8'h3C);
    drain("load2");
    chk("load2_writes_left", wq.size(), 0);

    wq.push_back('{6'd0, 32'hDEADBEEF});
    exp_q.push_back(8'h52);
    send(8'h07); send(8'h01);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    drain("load1");
    chk("load1_writes_left", wq.size(), 0);

    exp_q.push_back(8'h45);
    send(8'h07); send(8'h00);
    drain("load_zero");
    exp_q.push_back(8'h45);
    send(8'h07); send(8'd65);
    drain("load_big");
    exp_q.push_back(8'h45);
    send(8'h99);
    drain("unknown_op");

    exp_q.push_back(8'h52);
    send(8'h11);
    drain("step_mode");
    chk("step_mode_set", step_mode, 1);
    chk("step_mode_run", run, 0);
    n_step = 0;
    send(8'h0A);
    repeat (3) @(negedge clk);
    chk("step_unarmed", n_step, 0);
    send(8'h0D); send(8'h0A);
    repeat (3) @(negedge clk);
    chk("step_pulses", n_step, 1);
    chk("step_run", run, 0);
    send(8'h08); send(8'h0D);
    repeat (3) @(negedge clk);
    chk("cont_run", run, 1);
    chk("cont_mode", step_mode, 0);

    push_dump(8'h03, 129, 136'h1_0F0E0D0C0B0A09080706050403020100);
    exp_q.push_back(8'h52);
    send(8'h03);
    repeat (10) @(negedge clk);
    send(8'h11);
    fork
      begin @(posedge tx_done); rx_data = 8'h11; rx_valid = 1'b1; @(negedge clk); rx_valid = 1'b0; end
      begin repeat (300) @(negedge clk); end
    join_any
    disable fork;
    drain("overrun");
    chk("overrun_flag", overrun, 1);
    chk("overrun_exec", step_mode, 1);

    push_dump(8'h03, 129, 136'h0_A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5);
    g0 = n_got;
    send(8'h03);
    fork
      begin wait (n_got == g0 + 5); @(posedge tx_start); end
      begin repeat (500) @(negedge clk); end
    join_any
    disable fork;
    #2 rst = 1'b1;
    #1 chk("rst_tx_start", tx_start, 0);
    exp_q.delete();
    g1 = n_got;
    chk("rst_bytes_before", g1 - g0, 5);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("rst_no_more_bytes", n_got, g1);
    chk("rst_flags", {run, step_mode, overrun}, 0);
    exp_q.push_back(8'h52);
    send(8'h11);
    drain("after_rst");

    chk("handshake_errors", hs_err, 0);
    chk("bytes_left", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
